// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: one radix-2 step per cycle,
// shift-add multiply and restoring divide, with sign fix-up and special-case results.
module mdu_iter #(
    parameter int XLEN = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in_0,
    input  logic [XLEN-1:0] in_1,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] out,
    output logic            of,
    output logic            dz
);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN-1:0]     rem;
    logic [2*XLEN-1:0]   prod;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q;
    logic                sgn0_q;
    logic                dz_q;
    logic                of_q;

    // Operand sign handling at accept time
    logic                sgn0_c, sgn1_c, dz_c, of_c;
    logic [XLEN-1:0]     mag0_c, mag1_c;

    always_comb begin
        sgn0_c = in_0[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
        sgn1_c = in_1[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
        mag0_c = sgn0_c ? -in_0 : in_0;
        mag1_c = sgn1_c ? -in_1 : in_1;
        dz_c   = op[2] & (in_1 == '0);
        of_c   = ((op == OP_DIV) | (op == OP_REM)) & (in_0 == MIN_NEG) & (in_1 == '1);
    end

    // Datapath step: the multiply keeps the multiplier in the low half of prod and shifts
    // the running sum in from the top; the divide shifts the dividend out of the low half
    // and refills it with quotient bits.
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;

    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
        div_shift = {rem, prod[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
    end

    // Result selection with sign fix-up
    logic [2*XLEN-1:0]   prod_sgn;
    logic [XLEN-1:0]     quo_sgn, rem_sgn, fix_out;

    always_comb begin
        prod_sgn = neg_q ? -prod : prod;
        quo_sgn  = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        rem_sgn  = sgn0_q ? -rem : rem;
        fix_out  = '0;
        if (dz_q)
            fix_out = op_q[1] ? a_mag : '1;
        else if (of_q)
            fix_out = op_q[1] ? '0 : a_mag;
        else if (!op_q[2])
            fix_out = (op_q == OP_MUL) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
        else
            fix_out = op_q[1] ? rem_sgn : quo_sgn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            rem    <= '0;
            prod   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            sgn0_q <= 1'b0;
            dz_q   <= 1'b0;
            of_q   <= 1'b0;
            out    <= '0;
            of     <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q   <= op;
                        // Special cases skip CALC; a_mag then carries raw in_0 for the result.
                        a_mag  <= (dz_c || of_c) ? in_0 : mag0_c;
                        b_mag  <= mag1_c;
                        neg_q  <= sgn0_c ^ sgn1_c;
                        sgn0_q <= sgn0_c;
                        dz_q   <= dz_c;
                        of_q   <= of_c;
                        rem    <= '0;
                        prod   <= {{XLEN{1'b0}}, op[2] ? mag0_c : mag1_c};
                        cnt    <= '0;
                        state  <= (dz_c || of_c) ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (!op_q[2]) begin
                            prod <= {mul_sum, prod[XLEN-1:1]};
                        end else begin
                            rem              <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                            prod[XLEN-1:0]   <= {prod[XLEN-2:0], ~div_diff[XLEN]};
                        end
                        if (cnt == CNT_W'(XLEN - 1))
                            state <= FIX;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        out   <= fix_out;
                        of    <= of_q;
                        dz    <= dz_q;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == CALC) || (state == FIX);
    assign valid = (state == DONE);
endmodule

// File: tb/tb_mdu_iter.sv
// Directed and reference-model checks of mdu_iter at XLEN=32 and XLEN=8.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, out32;
    logic        ready32, busy32, valid32, of32, dz32;
    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, out8;
    logic        ready8, busy8, valid8, of8, dz8;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .in_0(a32), .in_1(b32),
        .flush(flush32), .ready(ready32), .busy(busy32), .valid(valid32),
        .out(out32), .of(of32), .dz(dz32)
    );

    mdu_iter #(.XLEN(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .in_0(a8), .in_1(b8),
        .flush(flush8), .ready(ready8), .busy(busy8), .valid(valid8),
        .out(out8), .of(of8), .dz(dz8)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w8, input bit s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = o; a32 = a; b32 = b;
        end
    endtask

    // lat = edge index at which valid is sampled high, start sampled at edge 0; -1 on timeout.
    task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke, input bit poke_done,
                       output logic [31:0] r, output logic rof, output logic rdz, output int lat);
        lat = -1;
        @(negedge clk);
        drive(w8, 1'b1, o, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, o, a, b);
        for (int k = 1; k <= 60; k++) begin
            if (k == poke) drive(w8, 1'b1, 3'd0, 32'h3, 32'h3);
            @(posedge clk); #1;
            if (k == poke) drive(w8, 1'b0, o, a, b);
            if (w8 ? valid8 : valid32) begin
                lat = k + 1;
                break;
            end
        end
        r   = w8 ? {24'h0, out8} : out32;
        rof = w8 ? of8 : of32;
        rdz = w8 ? dz8 : dz32;
        if (poke_done) drive(w8, 1'b1, 3'd1, 32'h5, 32'h5);
        @(posedge clk); #1;
        drive(w8, 1'b0, o, a, b);
    endtask

    function automatic logic [31:0] ref_out(input int xl, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint mask, half, ua, ub, sa, sb;
        logic [63:0] p;
        mask = (longint'(1) << xl) - 1;
        half = longint'(1) << (xl - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua ^ half) - half;
        sb = (ub ^ half) - half;
        p = '0;
        case (o)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >> xl;
            3'd2: p = (sa * ub) >> xl;
            3'd3: p = (ua * ub) >> xl;
            3'd4: p = (ub == 0) ? mask : (sa == -half && sb == -1) ? ua : sa / sb;
            3'd5: p = (ub == 0) ? mask : ua / ub;
            3'd6: p = (ub == 0) ? ua : (sa == -half && sb == -1) ? 0 : sa % sb;
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    logic [31:0] r, a, b, mask;
    logic        rof, rdz, dz_e, of_e;
    int          lat, vcount;
    logic [2:0]  o;

    initial begin
        // Reset state
        #1;
        chk("rst ready", ready32, 1'b1);
        chk("rst busy", busy32, 1'b0);
        chk("rst valid", valid32, 1'b0);
        chk("rst out", out32, 32'h0);
        chk("rst of/dz", {of32, dz32}, 2'b00);
        chk("rst8 ready/out", {ready8, out8}, {1'b1, 8'h0});
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Multiply, XLEN=32
        run(0, 3'd0, 32'd7, 32'hFFFFFFFD, 0, 0, r, rof, rdz, lat);
        chk("mul out", r, 32'hFFFFFFEB);
        chk("mul lat", 64'(lat), 64'd34);
        chk("mul of/dz", {rof, rdz}, 2'b00);
        run(0, 3'd1, 32'h80000000, 32'h80000000, 0, 0, r, rof, rdz, lat);
        chk("mulh", r, 32'h40000000);
        run(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, r, rof, rdz, lat);
        chk("mulhu", r, 32'hFFFFFFFE);
        run(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, r, rof, rdz, lat);
        chk("mulhsu", r, 32'hFFFFFFFF);

        // Divide, XLEN=32
        run(0, 3'd4, 32'hFFFFFFF9, 32'd2, 0, 0, r, rof, rdz, lat);
        chk("div -7/2", r, 32'hFFFFFFFD);
        chk("div lat", 64'(lat), 64'd34);
        run(0, 3'd6, 32'hFFFFFFF9, 32'd2, 0, 0, r, rof, rdz, lat);
        chk("rem -7/2", r, 32'hFFFFFFFF);
        run(0, 3'd5, 32'd100, 32'd7, 0, 0, r, rof, rdz, lat);
        chk("divu 100/7", r, 32'd14);
        run(0, 3'd7, 32'd100, 32'd7, 0, 0, r, rof, rdz, lat);
        chk("remu 100/7", r, 32'd2);

        // Special cases
        run(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0, r, rof, rdz, lat);
        chk("div ovf out", r, 32'h80000000);
        chk("div ovf of/dz", {rof, rdz}, 2'b10);
        chk("div ovf lat", 64'(lat), 64'd2);
        run(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 0, r, rof, rdz, lat);
        chk("rem ovf out", r, 32'h0);
        chk("rem ovf of", rof, 1'b1);
        run(0, 3'd4, 32'd5, 32'd0, 0, 0, r, rof, rdz, lat);
        chk("div dz out", r, 32'hFFFFFFFF);
        chk("div dz of/dz", {rof, rdz}, 2'b01);
        chk("div dz lat", 64'(lat), 64'd2);
        run(0, 3'd6, 32'd5, 32'd0, 0, 0, r, rof, rdz, lat);
        chk("rem dz out", r, 32'd5);
        chk("rem dz dz", rdz, 1'b1);

        // Reset in the middle of an operation
        @(negedge clk);
        drive(0, 1'b1, 3'd5, 32'd1000, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b0, 3'd5, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset busy", busy32, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid reset out", out32, 32'h0);
        chk("mid reset of/dz", {of32, dz32}, 2'b00);
        chk("mid reset ready/busy/valid", {ready32, busy32, valid32}, 3'b100);
        @(negedge clk);
        reset = 1'b0;

        // Flush in CALC
        run(0, 3'd5, 32'd100, 32'd7, 0, 0, r, rof, rdz, lat);
        chk("divu before flush", r, 32'd14);
        @(negedge clk);
        drive(0, 1'b1, 3'd5, 32'd50, 32'd3);
        @(posedge clk); #1;
        drive(0, 1'b0, 3'd5, 32'd50, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        chk("flush ready/busy", {ready32, busy32}, 2'b10);
        vcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid32) vcount++;
        end
        chk("flush no valid", 64'(vcount), 64'd0);
        chk("flush out kept", out32, 32'd14);

        // flush together with start in IDLE: flush wins
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 32'd2, 32'd2);
        flush32 = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b0, 3'd0, 32'd2, 32'd2);
        flush32 = 1'b0;
        chk("flush+start ready", ready32, 1'b1);

        // XLEN=8 directed, including start while busy and during DONE
        run(1, 3'd0, 32'd7, 32'hFD, 0, 0, r, rof, rdz, lat);
        chk("x8 mul", r, 32'hEB);
        chk("x8 mul lat", 64'(lat), 64'd10);
        run(1, 3'd4, 32'hF9, 32'd2, 0, 0, r, rof, rdz, lat);
        chk("x8 div", r, 32'hFD);
        run(1, 3'd6, 32'hF9, 32'd2, 0, 0, r, rof, rdz, lat);
        chk("x8 rem", r, 32'hFF);
        run(1, 3'd5, 32'd100, 32'd7, 3, 0, r, rof, rdz, lat);
        chk("x8 divu busy-start", r, 32'd14);
        chk("x8 divu lat", 64'(lat), 64'd10);
        run(1, 3'd7, 32'd100, 32'd7, 0, 1, r, rof, rdz, lat);
        chk("x8 remu", r, 32'd2);
        chk("x8 start in DONE ignored", {ready8, busy8}, 2'b10);

        // Reference-model vectors, both widths
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < (w == 1 ? 300 : 120); i++) begin
                o = 3'($urandom_range(0, 7));
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 15) == 0) b = 32'h0;
                if ($urandom_range(0, 15) == 0) begin a = 32'h80000000 >> (w * 24); b = '1; end
                mask = (w == 1) ? 32'hFF : 32'hFFFFFFFF;
                a = a & mask;
                b = b & mask;
                run(w[0], o, a, b, 0, 0, r, rof, rdz, lat);
                dz_e = o[2] && (b == 0);
                of_e = (o == 3'd4 || o == 3'd6) && (a == ((mask >> 1) + 1)) && (b == mask);
                chk("rand out", r, ref_out(w == 1 ? 8 : 32, o, a, b));
                chk("rand of/dz", {rof, rdz}, {of_e, dz_e});
                chk("rand lat", 64'(lat), (dz_e || of_e) ? 64'd2 : ((w == 1) ? 64'd10 : 64'd34));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
